vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Pixel-content stage that sits downstream of the VGA timing generator and drives the board colour/sync pins. It consumes the generator's data-enable and sync strobes, recovers pixel x/y internally, and produces one of four test patterns with syncs re-registered so colour and timing stay aligned. It gives the top level a self-checking image source independent of the timing generator's own colour outputs.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines per frame
- `SYNC_POL`, 0, asserted level of h/v sync (0 = active-low)
- `BOX_SIZE`, 32, side of moving box in pixels
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `mode_in`  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box
- `de_in`  in  1  display_on from timing generator
- `h_sync_in`  in  1  h_sync from timing generator
- `v_sync_in`  in  1  v_sync from timing generator
- `red`, `green`, `blue`  out  4 each  pixel colour
- `h_sync_out`, `v_sync_out`  out  1  syncs delayed to match colour
- `de_out`  out  1  de_in delayed to match colour
- `frame_tick`  out  1  one-cycle pulse per frame

## Operation
- **Coordinates.** A cycle with `de_in` high has x = 0 if `de_in` was low the previous cycle, else previous x+1. x saturates at H_ACTIVE-1. y increments on each `de_in` falling edge, saturates at V_ACTIVE-1, and clears to 0 on the v_sync assertion edge.
- **Frame start** = `v_sync_in` changing to the SYNC_POL level. On that edge:
  - `mode_in` is latched into the active mode; mode never changes mid-frame.
  - The box position updates.
  - `frame_tick` pulses.
- **Pattern definitions**, evaluated only when `de_in` is high:
  - Mode 0: white (F,F,F).
  - Mode 1: eight bars of width H_ACTIVE/8. Bar index i = 0..7 from left; colour index c = 7-i. red = c[2]?F:0, green = c[1]?F:0, blue = c[0]?F:0. So bar 0 is white and bar 7 is black. Bars are tracked with a bar counter plus an in-bar pixel counter, not a divider.
  - Mode 2: all channels F if x[5]^y[5], else 0.
  - Mode 3: green (0,F,0) where bx ≤ x < bx+BOX_SIZE and by ≤ y < by+BOX_SIZE; blue (0,0,F) elsewhere.
- **Box motion.** At each frame start, bx and by each step 1 pixel in their current direction.
  - bx range is 0..H_ACTIVE-BOX_SIZE; by range is 0..V_ACTIVE-BOX_SIZE.
  - At a limit, that axis's direction flips and the same update steps 1 pixel the other way. There is no dwell at the edge.
- **Blanking.** Colour outputs are 0 whenever `de_out` is low.
- **Reset values:**
  - All colours 0; `de_out` 0; `frame_tick` 0.
  - Sync outputs at the deasserted level (~SYNC_POL).
  - x, y, bx, by = 0; both directions +; active mode 0.
- **Edge detectors.** After reset, the edge detectors' previous-value registers hold the deasserted level. If `v_sync_in` is already asserted when reset is released, a frame start is detected on the first cycle after release.

## Timing
- Fixed latency of 1 cycle from inputs to all outputs. Colour, `de_out`, `h_sync_out` and `v_sync_out` for input cycle n appear registered at cycle n+1.
- `frame_tick` is high for exactly the one cycle in which `v_sync_out` first shows the asserted level.
- The box position and latched mode take effect from the first cycle after the frame-start edge. They are therefore stable for the whole next active region.
- If a frame start and a `de_in` falling edge occur on the same cycle, the y clear wins.
- Reset mid-frame: outputs go to reset values on the next cycle. The pattern resumes correctly from the next `de_in` rising edge. y is correct only after the next frame start.

## Structure
- Shared package `vga_pkg` holds:
  - the mode enum `pattern_mode_t` (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_BOX);
  - the default 640x480 constants;
  - the colour constants.
- One natural sub-module: `box_mover`, which holds the bx/by/direction registers and is stepped by `frame_tick`.
- Total RTL is about 200 lines.

## Test plan
- Drive 640x480 timing from the existing timing generator with mode 1. Line 10 output: pixels 0–79 = (F,F,F), 80–159 = (F,F,0), 560–639 = (0,0,0). Colour is 0 while `de_out` is low.
- Mode 2, sampled at y = 0: x = 31 → 0, x = 32 → F. At y = 32: x = 32 → 0.
- Change `mode_in` from 0 to 1 mid-frame. Output stays white until the next frame start, then bars appear.
- Mode 3 over 3 frames from reset: box at (1,1), (2,2), (3,3). Pixel (3,3) is green and pixel (35,3) is blue in the third frame.
- Preload bx = 608 via 608 frames (the bench may force it). The next frame gives bx = 607 with the x direction now negative.
- Assert `rst` mid-line. Next cycle: colours 0 and syncs high (SYNC_POL = 0). Latency stays 1 cycle after release. `frame_tick` count equals the number of v_sync assertion edges seen after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern stage: pattern modes,
// default 640x480 geometry and the colour values the patterns are built from.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_BOX_SIZE = 32;

  localparam logic [3:0] COL_F = 4'hF;
  localparam logic [3:0] COL_0 = 4'h0;

  localparam rgb_t RGB_BLACK = '{r: COL_0, g: COL_0, b: COL_0};
  localparam rgb_t RGB_WHITE = '{r: COL_F, g: COL_F, b: COL_F};
  localparam rgb_t RGB_GREEN = '{r: COL_0, g: COL_F, b: COL_0};
  localparam rgb_t RGB_BLUE  = '{r: COL_0, g: COL_0, b: COL_F};

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Timing strobes in from the VGA timing generator and pixel/sync pins out.
// master = timing source/board side, slave = the pattern generator.
interface vga_pattern_gen_if;
  logic [1:0] mode_in;
  logic       de_in;
  logic       h_sync_in;
  logic       v_sync_in;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       h_sync_out;
  logic       v_sync_out;
  logic       de_out;
  logic       frame_tick;

  modport master (
    output mode_in, de_in, h_sync_in, v_sync_in,
    input  red, green, blue, h_sync_out, v_sync_out, de_out, frame_tick
  );

  modport slave (
    input  mode_in, de_in, h_sync_in, v_sync_in,
    output red, green, blue, h_sync_out, v_sync_out, de_out, frame_tick
  );
endinterface

// File: rtl/box_mover.sv
// Bouncing box origin: each step moves bx/by one pixel; at a limit the axis
// reverses and steps back in the same update (no dwell at the edge).
module box_mover #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_step,
  output logic [XW-1:0] o_bx,
  output logic [YW-1:0] o_by
);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - BOX_SIZE);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - BOX_SIZE);

  logic [XW-1:0] r_bx;
  logic [YW-1:0] r_by;
  logic          r_dx_pos;
  logic          r_dy_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bx     <= '0;
      r_by     <= '0;
      r_dx_pos <= 1'b1;
      r_dy_pos <= 1'b1;
    end else if (i_step) begin
      if (r_dx_pos) begin
        if (r_bx == X_MAX) begin
          r_dx_pos <= 1'b0;
          r_bx     <= r_bx - XW'(1);
        end else begin
          r_bx <= r_bx + XW'(1);
        end
      end else if (r_bx == '0) begin
        r_dx_pos <= 1'b1;
        r_bx     <= r_bx + XW'(1);
      end else begin
        r_bx <= r_bx - XW'(1);
      end

      if (r_dy_pos) begin
        if (r_by == Y_MAX) begin
          r_dy_pos <= 1'b0;
          r_by     <= r_by - YW'(1);
        end else begin
          r_by <= r_by + YW'(1);
        end
      end else if (r_by == '0) begin
        r_dy_pos <= 1'b1;
        r_by     <= r_by + YW'(1);
      end else begin
        r_by <= r_by - YW'(1);
      end
    end
  end

  assign o_bx = r_bx;
  assign o_by = r_by;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage: recovers x/y from DE/sync strobes and emits one of
// four patterns, with syncs and DE re-registered so everything lands together.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter bit SYNC_POL = 1'b0,
  parameter int BOX_SIZE = DEF_BOX_SIZE
) (
  input logic              clk,
  input logic              rst,
  vga_pattern_gen_if.slave vga
);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W);

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (v == XW'(H_ACTIVE - 1)) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (v == YW'(V_ACTIVE - 1)) ? v : v + YW'(1);
  endfunction

  logic          r_de_prev;
  logic          r_vs_prev;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [2:0]    r_bar;
  logic [BW-1:0] r_bcnt;
  pattern_mode_t r_mode;

  logic          w_fs;
  logic          w_de_fall;
  logic [XW-1:0] w_x;
  logic [2:0]    w_bar;
  logic [2:0]    w_c;
  logic [BW-1:0] w_bcnt;
  logic [XW-1:0] w_bx;
  logic [YW-1:0] w_by;
  logic          w_in_box;
  rgb_t          w_pix;

  rgb_t          r_pix_p1;
  logic          r_de_p1;
  logic          r_hs_p1;
  logic          r_vs_p1;
  logic          r_tick_p1;

  box_mover #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .BOX_SIZE(BOX_SIZE),
    .XW      (XW),
    .YW      (YW)
  ) u_box (
    .clk   (clk),
    .rst   (rst),
    .i_step(w_fs),
    .o_bx  (w_bx),
    .o_by  (w_by)
  );

  // Stage p0: coordinates and bar position of the pixel presented this cycle
  always_comb begin
    w_fs      = (vga.v_sync_in == SYNC_POL) && (r_vs_prev != SYNC_POL);
    w_de_fall = r_de_prev && !vga.de_in;
    w_x       = '0;
    w_bar     = '0;
    w_bcnt    = '0;
    if (r_de_prev) begin
      w_x = sat_inc_x(r_x);
      if (r_bcnt == BW'(BAR_W - 1)) begin
        w_bar = (r_bar == 3'd7) ? r_bar : r_bar + 3'd1;
      end else begin
        w_bcnt = r_bcnt + BW'(1);
        w_bar  = r_bar;
      end
    end

    w_c      = ~w_bar;
    w_in_box = (int'(w_x) >= int'(w_bx)) && (int'(w_x) < int'(w_bx) + BOX_SIZE) &&
               (int'(r_y) >= int'(w_by)) && (int'(r_y) < int'(w_by) + BOX_SIZE);

    w_pix = RGB_BLACK;
    unique case (r_mode)
      MODE_SOLID: w_pix = RGB_WHITE;
      MODE_BARS:  w_pix = '{r: w_c[2] ? COL_F : COL_0,
                            g: w_c[1] ? COL_F : COL_0,
                            b: w_c[0] ? COL_F : COL_0};
      MODE_CHECK: w_pix = (w_x[5] ^ r_y[5]) ? RGB_WHITE : RGB_BLACK;
      MODE_BOX:   w_pix = w_in_box ? RGB_GREEN : RGB_BLUE;
    endcase
    if (!vga.de_in) w_pix = RGB_BLACK;
  end

  // Stage p1: registered pixel, strobes and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_prev <= 1'b0;
      r_vs_prev <= ~SYNC_POL;
      r_x       <= '0;
      r_y       <= '0;
      r_bar     <= '0;
      r_bcnt    <= '0;
      r_mode    <= MODE_SOLID;
      r_pix_p1  <= RGB_BLACK;
      r_de_p1   <= 1'b0;
      r_hs_p1   <= ~SYNC_POL;
      r_vs_p1   <= ~SYNC_POL;
      r_tick_p1 <= 1'b0;
    end else begin
      r_de_prev <= vga.de_in;
      r_vs_prev <= vga.v_sync_in;
      if (vga.de_in) begin
        r_x    <= w_x;
        r_bar  <= w_bar;
        r_bcnt <= w_bcnt;
      end
      // A frame start on the same cycle as a DE falling edge clears y
      if (w_fs) begin
        r_y    <= '0;
        r_mode <= pattern_mode_t'(vga.mode_in);
      end else if (w_de_fall) begin
        r_y <= sat_inc_y(r_y);
      end
      r_pix_p1  <= w_pix;
      r_de_p1   <= vga.de_in;
      r_hs_p1   <= vga.h_sync_in;
      r_vs_p1   <= vga.v_sync_in;
      r_tick_p1 <= w_fs;
    end
  end

  assign vga.red        = r_pix_p1.r;
  assign vga.green      = r_pix_p1.g;
  assign vga.blue       = r_pix_p1.b;
  assign vga.de_out     = r_de_p1;
  assign vga.h_sync_out = r_hs_p1;
  assign vga.v_sync_out = r_vs_p1;
  assign vga.frame_tick = r_tick_p1;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: abbreviated 640-wide lines, short DE
// pulses to advance y, and hand-computed pixel expectations.
module tb_vga_pattern_gen;
  localparam int H = 640;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   tick_cnt;
  logic [11:0] obs [H];
  logic        deo [H];
  logic [11:0] blank_rgb;
  logic        blank_de;
  logic        ft;
  logic        vso;

  vga_pattern_gen_if vga ();

  vga_pattern_gen #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .SYNC_POL(1'b0),
    .BOX_SIZE(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick(input logic de, input logic hs, input logic vs);
    vga.de_in     = de;
    vga.h_sync_in = hs;
    vga.v_sync_in = vs;
    @(posedge clk);
    #1;
    if (vga.frame_tick === 1'b1) tick_cnt++;
  endtask

  task automatic line();
    for (int i = 0; i < H; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      obs[i] = {vga.red, vga.green, vga.blue};
      deo[i] = vga.de_out;
    end
    tick(1'b0, 1'b1, 1'b1);
    blank_rgb = {vga.red, vga.green, vga.blue};
    blank_de  = vga.de_out;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic fstart();
    tick(1'b0, 1'b1, 1'b0);
    ft  = vga.frame_tick;
    vso = vga.v_sync_out;
    tick(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    tick_cnt = 0;
    rst      = 1'b1;
    vga.mode_in = 2'd1;

    // Reset held with v_sync already asserted
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    chk("rst_rgb",  {vga.red, vga.green, vga.blue}, 12'h000);
    chk("rst_de",   vga.de_out, 1'b0);
    chk("rst_hs",   vga.h_sync_out, 1'b1);
    chk("rst_vs",   vga.v_sync_out, 1'b1);
    chk("rst_tick", vga.frame_tick, 1'b0);

    rst = 1'b0;
    fstart();
    chk("fs_after_release_tick", ft, 1'b1);
    chk("fs_after_release_vs",   vso, 1'b0);

    // Bars on line 10
    pulses(10);
    line();
    chk("bars_de_first", deo[0], 1'b1);
    chk("bars_px0",   obs[0],   12'hFFF);
    chk("bars_px79",  obs[79],  12'hFFF);
    chk("bars_px80",  obs[80],  12'hFF0);
    chk("bars_px159", obs[159], 12'hFF0);
    chk("bars_px320", obs[320], 12'h0FF);
    chk("bars_px560", obs[560], 12'h000);
    chk("bars_px639", obs[639], 12'h000);
    chk("blank_rgb",  blank_rgb, 12'h000);
    chk("blank_de",   blank_de, 1'b0);

    // Mode change mid-frame waits for the next frame start
    vga.mode_in = 2'd0;
    fstart();
    line();
    chk("solid_px639", obs[639], 12'hFFF);
    vga.mode_in = 2'd1;
    line();
    chk("midframe_still_white", obs[639], 12'hFFF);
    fstart();
    line();
    chk("newframe_bars_px639", obs[639], 12'h000);
    chk("newframe_bars_px80",  obs[80],  12'hFF0);

    // Checkerboard
    vga.mode_in = 2'd2;
    fstart();
    line();
    chk("chk_y0_x31", obs[31], 12'h000);
    chk("chk_y0_x32", obs[32], 12'hFFF);
    pulses(31);
    line();
    chk("chk_y32_x32", obs[32], 12'h000);
    chk("chk_y32_x31", obs[31], 12'hFFF);

    // Reset mid-line
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    chk("midrst_rgb", {vga.red, vga.green, vga.blue}, 12'h000);
    chk("midrst_de",  vga.de_out, 1'b0);
    chk("midrst_hs",  vga.h_sync_out, 1'b1);
    chk("midrst_vs",  vga.v_sync_out, 1'b1);
    rst = 1'b0;
    tick_cnt = 0;
    tick(1'b0, 1'b1, 1'b1);

    // Box over three frames from reset
    vga.mode_in = 2'd3;
    fstart();
    line();
    chk("box_latency_de", deo[0], 1'b1);
    chk("box1_y0_x1", obs[1], 12'h00F);
    line();
    chk("box1_y1_x0",  obs[0],  12'h00F);
    chk("box1_y1_x1",  obs[1],  12'h0F0);
    chk("box1_y1_x32", obs[32], 12'h0F0);
    chk("box1_y1_x33", obs[33], 12'h00F);
    fstart();
    fstart();
    pulses(3);
    line();
    chk("box3_x2",  obs[2],  12'h00F);
    chk("box3_x3",  obs[3],  12'h0F0);
    chk("box3_x34", obs[34], 12'h0F0);
    chk("box3_x35", obs[35], 12'h00F);
    chk("tick_count_3", tick_cnt, 3);

    // Right-edge bounce: 608 frames reach bx=608, the 609th turns back
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 609; i++) fstart();
    pulses(287);
    line();
    chk("bounce_x606", obs[606], 12'h00F);
    chk("bounce_x607", obs[607], 12'h0F0);
    chk("bounce_x638", obs[638], 12'h0F0);
    chk("bounce_x639", obs[639], 12'h00F);
    fstart();
    pulses(286);
    line();
    chk("back_x605", obs[605], 12'h00F);
    chk("back_x606", obs[606], 12'h0F0);
    chk("back_x637", obs[637], 12'h0F0);
    chk("back_x638", obs[638], 12'h00F);
    chk("tick_count_610", tick_cnt, 610);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
